// File: rtl/fwd_scoreboard.sv
// EX-stage forwarding scoreboard: tracks in-flight register writes over DEPTH post-EX stages,
// producing per-source forwarding selects and an operand-not-ready stall.
module fwd_scoreboard #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned LAT_W   = 2,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic                      ex_regwrite,
    input  logic [ADDR_W-1:0]         ex_rd,
    input  logic [LAT_W-1:0]          ex_lat,
    input  logic [NUM_SRC*ADDR_W-1:0] ex_src,
    input  logic                      freeze,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      fwd_stall,
    output logic [CNT_W-1:0]          stall_count,
    output logic [DEPTH-1:0]          stage_valid
);

    localparam int unsigned MAX_REM = DEPTH - 1;

    // Index k-1 holds stage k (1 = MEM, 2 = WB, ...).
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0]             wr_q, wr_d;
    logic [DEPTH-1:0][ADDR_W-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][LAT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic [NUM_SRC-1:0]           hazard;
    logic [NUM_SRC-1:0]           found;
    logic [LAT_W-1:0]             lat_clamped;

    // Youngest matching producer decides: forward if ready, otherwise flag a hazard.
    always_comb begin
        fwd_sel = '0;
        hazard  = '0;
        found   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!found[i] && valid_q[k] && wr_q[k] && (rd_q[k] != '0)
                    && (rd_q[k] == ex_src[i*ADDR_W +: ADDR_W])) begin
                    found[i] = 1'b1;
                    if (rem_q[k] == '0) begin
                        fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    end else begin
                        hazard[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign fwd_stall = ex_valid && (|hazard);

    // Clamp so every producer is ready by the last tracked stage.
    always_comb begin
        if (32'(ex_lat) > MAX_REM) begin
            lat_clamped = LAT_W'(MAX_REM);
        end else begin
            lat_clamped = ex_lat;
        end
    end

    always_comb begin
        valid_d = valid_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        if (!freeze) begin
            valid_d[0] = ex_valid && !fwd_stall;
            wr_d[0]    = ex_regwrite;
            rd_d[0]    = ex_rd;
            rem_d[0]   = lat_clamped;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                wr_d[k]    = wr_q[k-1];
                rd_d[k]    = rd_q[k-1];
                rem_d[k]   = (rem_q[k-1] == '0) ? '0 : rem_q[k-1] - LAT_W'(1);
            end
            if (fwd_stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stage_valid = valid_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: two configurations share one stimulus stream; an issue-history
// reference model predicts outputs into a queue that a negedge monitor pops and compares.
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, ex_valid, ex_regwrite, freeze;
    logic [4:0]  ex_rd;
    logic [1:0]  ex_lat;
    logic [14:0] ex_src;

    logic [3:0]  sel_a;
    logic        stall_a;
    logic [15:0] cnt_a;
    logic [1:0]  sv_a;
    logic [8:0]  sel_b;
    logic        stall_b;
    logic [1:0]  cnt_b;
    logic [3:0]  sv_b;

    fwd_scoreboard #(.NUM_SRC(2), .ADDR_W(5), .DEPTH(2), .LAT_W(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_rd(ex_rd), .ex_lat(ex_lat), .ex_src(ex_src[9:0]), .freeze(freeze),
        .fwd_sel(sel_a), .fwd_stall(stall_a), .stall_count(cnt_a), .stage_valid(sv_a)
    );

    fwd_scoreboard #(.NUM_SRC(3), .ADDR_W(5), .DEPTH(4), .LAT_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_rd(ex_rd), .ex_lat(ex_lat), .ex_src(ex_src), .freeze(freeze),
        .fwd_sel(sel_b), .fwd_stall(stall_b), .stall_count(cnt_b), .stage_valid(sv_b)
    );

    typedef struct packed {
        logic [3:0]  sel_a;
        logic        stall_a;
        logic [1:0]  sv_a;
        logic [15:0] cnt_a;
        logic [8:0]  sel_b;
        logic        stall_b;
        logic [3:0]  sv_b;
        logic [1:0]  cnt_b;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic last_stall = 1'b0;

    // Reference model: a log of issued instructions indexed by advance number.
    // An instruction issued at advance n sits at pipeline age (adv - n).
    int         adv[2]      = '{0, 0};
    int         rst_mark[2] = '{0, 0};
    int         cnt[2]      = '{0, 0};
    logic       hv[2][16];
    logic       hw[2][16];
    logic [4:0] hrd[2][16];
    logic [1:0] hlat[2][16];

    function automatic logic live(input int j, input int a);
        int n;
        n = adv[j] - a;
        if (n < rst_mark[j]) return 1'b0;
        return hv[j][n % 16];
    endfunction

    function automatic void evaluate(input int j, input int d, input int ns, input int sw,
                                     input logic v, input logic [14:0] src,
                                     output logic [8:0] sel, output logic stall,
                                     output logic [3:0] sv);
        logic       haz;
        logic [4:0] s;
        int         best, lc, idx;
        haz = 1'b0;
        sel = '0;
        sv  = '0;
        for (int a = 1; a <= d; a++) begin
            if (live(j, a)) sv[a-1] = 1'b1;
        end
        for (int i = 0; i < ns; i++) begin
            s    = src[i*5 +: 5];
            best = 0;
            for (int a = 1; a <= d; a++) begin
                idx = (adv[j] - a) % 16;
                if (best == 0 && live(j, a) && hw[j][idx] && hrd[j][idx] != 5'd0
                    && hrd[j][idx] == s) best = a;
            end
            if (best != 0) begin
                idx = (adv[j] - best) % 16;
                lc  = (int'(hlat[j][idx]) < d - 1) ? int'(hlat[j][idx]) : d - 1;
                if (best > lc) sel = sel | (9'(best) << (i * sw));
                else haz = 1'b1;
            end
        end
        stall = v && haz;
    endfunction

    function automatic void step(input int j, input int d, input int ns, input int sw,
                                 input int cmax);
        logic [8:0] sel;
        logic       st;
        logic [3:0] sv;
        evaluate(j, d, ns, sw, ex_valid, ex_src, sel, st, sv);
        if (!rst_n) begin
            rst_mark[j] = adv[j];
            cnt[j]      = 0;
        end else if (!freeze) begin
            if (st && cnt[j] < cmax) cnt[j] = cnt[j] + 1;
            hv[j][adv[j] % 16]   = ex_valid && !st;
            hw[j][adv[j] % 16]   = ex_regwrite;
            hrd[j][adv[j] % 16]  = ex_rd;
            hlat[j][adv[j] % 16] = ex_lat;
            adv[j] = adv[j] + 1;
        end
    endfunction

    function automatic logic [14:0] mk(input logic [4:0] s0, input logic [4:0] s1,
                                       input logic [4:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic cycle(input logic v, input logic wr, input logic [4:0] rd,
                         input logic [1:0] lat, input logic [14:0] src,
                         input logic frz, input logic rst, input logic chk);
        exp_t       e;
        logic [8:0] sel;
        logic       st;
        logic [3:0] sv;
        ex_valid    = v;
        ex_regwrite = wr;
        ex_rd       = rd;
        ex_lat      = lat;
        ex_src      = src;
        freeze      = frz;
        rst_n       = rst;
        if (chk) begin
            evaluate(0, 2, 2, 2, v, src, sel, st, sv);
            e.sel_a   = sel[3:0];
            e.stall_a = st;
            e.sv_a    = sv[1:0];
            e.cnt_a   = 16'(cnt[0]);
            evaluate(1, 4, 3, 3, v, src, sel, st, sv);
            e.sel_b   = sel;
            e.stall_b = st;
            e.sv_b    = sv;
            e.cnt_b   = 2'(cnt[1]);
            last_stall = e.stall_a | e.stall_b;
            expq.push_back(e);
        end
        @(posedge clk);
        step(0, 2, 2, 2, 65535);
        step(1, 4, 3, 3, 3);
        #1;
    endtask

    task automatic run(input logic v, input logic wr, input logic [4:0] rd,
                       input logic [1:0] lat, input logic [14:0] src, input logic frz);
        cycle(v, wr, rd, lat, src, frz, 1'b1, 1'b1);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are combinationally valid every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("sel_a",   16'(sel_a),   16'(e.sel_a));
                check("stall_a", 16'(stall_a), 16'(e.stall_a));
                check("sv_a",    16'(sv_a),    16'(e.sv_a));
                check("cnt_a",   cnt_a,        e.cnt_a);
                check("sel_b",   16'(sel_b),   16'(e.sel_b));
                check("stall_b", 16'(stall_b), 16'(e.stall_b));
                check("sv_b",    16'(sv_b),    16'(e.sv_b));
                check("cnt_b",   16'(cnt_b),   16'(e.cnt_b));
            end
        end
    end

    initial begin
        logic        v, wr, frz, rst;
        logic [4:0]  rd;
        logic [1:0]  lat;
        logic [14:0] src;

        cycle(1'b0, 1'b0, 5'd0, 2'd0, 15'd0, 1'b0, 1'b0, 1'b0);
        // fill, then mid-operation reset
        run(1, 1, 5'd5, 2'd0, mk(0, 0, 0), 0);
        run(1, 1, 5'd6, 2'd1, mk(0, 0, 0), 0);
        run(1, 1, 5'd7, 2'd3, mk(0, 0, 0), 0);
        cycle(0, 0, 5'd0, 2'd0, mk(5, 6, 7), 0, 0, 1);
        run(1, 1, 5'd1, 2'd0, mk(5, 6, 7), 0);
        // ALU chain
        run(1, 1, 5'd5, 2'd0, mk(0, 0, 0), 0);
        run(1, 1, 5'd9, 2'd0, mk(1, 2, 0), 0);
        run(1, 1, 5'd6, 2'd0, mk(5, 0, 0), 0);
        run(1, 1, 5'd7, 2'd0, mk(5, 0, 0), 0);
        run(1, 1, 5'd7, 2'd0, mk(5, 0, 0), 0);
        // load-use
        run(1, 1, 5'd8, 2'd1, mk(0, 0, 0), 0);
        run(1, 1, 5'd10, 2'd0, mk(0, 8, 0), 0);
        run(1, 1, 5'd10, 2'd0, mk(0, 8, 0), 0);
        // priority
        run(1, 1, 5'd3, 2'd1, mk(0, 0, 0), 0);
        run(1, 1, 5'd3, 2'd0, mk(0, 0, 0), 0);
        run(1, 1, 5'd11, 2'd0, mk(3, 3, 3), 0);
        run(1, 1, 5'd3, 2'd0, mk(0, 0, 0), 0);
        run(1, 1, 5'd3, 2'd1, mk(0, 0, 0), 0);
        run(1, 1, 5'd11, 2'd0, mk(3, 0, 3), 0);
        run(1, 1, 5'd11, 2'd0, mk(3, 0, 3), 0);
        // zero register and non-writing producer
        run(1, 1, 5'd0, 2'd0, mk(0, 0, 0), 0);
        run(1, 1, 5'd12, 2'd0, mk(0, 0, 0), 0);
        run(1, 0, 5'd4, 2'd0, mk(0, 0, 0), 0);
        run(1, 1, 5'd12, 2'd0, mk(4, 4, 4), 0);
        // freeze with a pending load
        run(1, 1, 5'd8, 2'd1, mk(0, 0, 0), 0);
        repeat (3) run(1, 1, 5'd10, 2'd0, mk(0, 8, 0), 1);
        repeat (2) run(1, 1, 5'd10, 2'd0, mk(0, 8, 0), 0);
        // long latencies and clamping
        run(1, 1, 5'd12, 2'd2, mk(0, 0, 0), 0);
        repeat (3) run(1, 1, 5'd14, 2'd0, mk(0, 0, 12), 0);
        run(1, 1, 5'd13, 2'd3, mk(0, 0, 0), 0);
        repeat (5) run(1, 1, 5'd14, 2'd0, mk(0, 0, 13), 0);
        run(0, 0, 5'd0, 2'd0, mk(0, 0, 0), 0);

        v = 1'b0; wr = 1'b0; rd = '0; lat = '0; src = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!(last_stall && $urandom_range(0, 3) != 0)) begin
                v   = ($urandom_range(0, 7) != 0);
                wr  = ($urandom_range(0, 3) != 0);
                rd  = 5'($urandom_range(0, 3));
                lat = 2'($urandom_range(0, 3));
                src = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         5'($urandom_range(0, 3)));
            end
            frz = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 199) != 0);
            cycle(v, wr, rd, lat, src, frz, rst, 1'b1);
        end

        repeat (2) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL drain: %0d expected entries left, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
